input_feed_ctrl: RTL and testbench
==================================

INPUT_FEED_CTRL -- requirements
Module: input_feed_ctrl

Interface
REQ-001 SHALL take parameter ADDRWIDTH, default 8, read-address width of the input tile buffer.
REQ-002 SHALL take array geometry from shared config macros: `ARRAYWIDTH (W), `DATASIZE (D), `DSP_DELAY (L).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to feed one W x W tile; honoured only in IDLE.
REQ-006 base_addr  input  ADDRWIDTH  buffer address of tile column 0, sampled on accepted start.
REQ-007 rd_en  output  1  buffer read strobe.
REQ-008 rd_addr  output  ADDRWIDTH  buffer read address.
REQ-009 rd_data  input  W*D  one tile column; row r in bits [r*D +: D]; valid exactly 1 cycle after rd_en.
REQ-010 load_en  output  1  load strobe broadcast to all W input shifter rows.
REQ-011 load_data  output  W*D  per-row shifter input, row r in bits [r*D +: D].
REQ-012 out_en  output  1  stream enable broadcast to all W shifter rows.
REQ-013 sr_rst  output  1  one-cycle re-arm pulse to all shifter rows (OR-ed with rst at top level).
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse when tile fully streamed.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, STREAM, DONE.
REQ-017 IDLE->LOAD on start; captured base_addr, column counter cleared to 0.
REQ-018 LOAD: rd_en high for exactly W consecutive cycles, rd_addr = base_addr + k for k = 0..W-1, wrap modulo 2^ADDRWIDTH.
REQ-019 load_en SHALL be rd_en delayed 1 cycle; load_data = rd_data registered-free pass-through in that cycle (W load_en pulses, no gaps).
REQ-020 LOAD->STREAM on the cycle after the last load_en; out_en SHALL be low during LOAD.
REQ-021 STREAM: out_en held high for exactly N = L*(W-1) + W consecutive cycles (drains row W-1, the longest-delayed row).
REQ-022 STREAM->DONE after N out_en cycles; DONE asserts done and sr_rst for exactly 1 cycle, then ->IDLE.
REQ-023 load_en and out_en SHALL never be high in the same cycle.
REQ-024 start while busy (including DONE) SHALL be ignored, not queued.
REQ-025 Back-to-back tiles: start in the cycle after DONE SHALL be accepted; minimum tile period W + 1 + N + 1 cycles.
REQ-026 Stream counter SHALL be sized for N (clog2(N+1) bits minimum); no wrap within a tile.

Reset
REQ-027 On rst: state IDLE; rd_en, load_en, out_en, sr_rst, busy, done = 0; rd_addr, load_data-select, counters = 0.
REQ-028 rst mid-LOAD or mid-STREAM SHALL abort the tile immediately, no done pulse; next start accepted normally.

Structure
REQ-029 W, D, L SHALL come from the shared config header; N computed as a localparam in-module, not in config.
REQ-030 Single flat module; FSM and counters inline, no sub-modules.

Verification (W=4, D=8, L=4, N=16)
REQ-031 start, base_addr=0x10 -> rd_en cycles 1..4, rd_addr 0x10..0x13; load_en cycles 2..5 carrying buffer columns in order.
REQ-032 Same run -> out_en high cycles 6..21 (16 cycles), done and sr_rst high cycle 22 only, busy low cycle 23.
REQ-033 base_addr=0xFE -> rd_addr 0xFE, 0xFF, 0x00, 0x01.
REQ-034 start pulsed again in LOAD and STREAM -> ignored; exactly one done; start on cycle after done -> second tile, identical timing.
REQ-035 rst asserted during STREAM cycle 10 -> all outputs 0 next cycle, no done; subsequent start runs full tile.
REQ-036 End-to-end with 4 shifter rows and identity-pattern tile -> row r emits its 4 values starting out_en cycle 4r+1 (3r delay + r zeros).

Source files
------------

// File: rtl/input_feed_ctrl_pkg.sv
// input_feed_ctrl_pkg: shared array geometry macros and FSM state type for the input feed controller
`ifndef INPUT_FEED_CTRL_CFG
`define INPUT_FEED_CTRL_CFG
`define ARRAYWIDTH 4
`define DATASIZE 8
`define DSP_DELAY 4
`endif

package input_feed_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } state_t;

endpackage

// File: rtl/input_feed_ctrl.sv
// input_feed_ctrl: reads one W x W tile column-by-column from the tile buffer into the input shifters, then streams it out
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, base_addr    tile request (honoured in IDLE only) and buffer address of column 0
//   rd_en, rd_addr      buffer read strobe and address; rd_data returns one cycle later
//   load_en, load_data  shifter load strobe and per-row data (row r in bits [r*D +: D])
//   out_en, sr_rst      shifter stream enable and one-cycle re-arm pulse
//   busy, done          not-IDLE flag and end-of-tile pulse
module input_feed_ctrl
    import input_feed_ctrl_pkg::*;
#(
    parameter int ADDRWIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [ADDRWIDTH-1:0]               base_addr,
    output logic                               rd_en,
    output logic [ADDRWIDTH-1:0]               rd_addr,
    input  logic [`ARRAYWIDTH*`DATASIZE-1:0]   rd_data,
    output logic                               load_en,
    output logic [`ARRAYWIDTH*`DATASIZE-1:0]   load_data,
    output logic                               out_en,
    output logic                               sr_rst,
    output logic                               busy,
    output logic                               done
);

    localparam int W  = `ARRAYWIDTH;
    localparam int L  = `DSP_DELAY;
    // Stream length drains the most-delayed row (W-1) completely.
    localparam int N  = L * (W - 1) + W;
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] LOAD_LAST   = CW'(W - 1);
    localparam logic [CW-1:0] LOAD_END    = CW'(W);
    localparam logic [CW-1:0] STREAM_LAST = CW'(N - 1);

    state_t        state;
    logic [CW-1:0] cnt;

    // Buffer data is valid exactly in the load_en cycle, so it is forwarded unregistered.
    assign load_data = load_en ? rd_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            load_en <= 1'b0;
            out_en  <= 1'b0;
            sr_rst  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            load_en <= rd_en;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        cnt     <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= base_addr;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    // cnt 0..W-1 issue reads; cnt == W is the final load_en cycle.
                    cnt <= cnt + CW'(1);
                    if (cnt == LOAD_LAST)
                        rd_en <= 1'b0;
                    else if (rd_en)
                        rd_addr <= rd_addr + ADDRWIDTH'(1);
                    if (cnt == LOAD_END) begin
                        state  <= STREAM;
                        out_en <= 1'b1;
                        cnt    <= '0;
                    end
                end
                STREAM: begin
                    if (cnt == STREAM_LAST) begin
                        state  <= DONE;
                        out_en <= 1'b0;
                        done   <= 1'b1;
                        sr_rst <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done   <= 1'b0;
                    sr_rst <= 1'b0;
                    busy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_feed_ctrl.sv
// tb_input_feed_ctrl: directed self-checking bench for input_feed_ctrl (W=4, D=8, L=4, N=16)
module tb_input_feed_ctrl;

    localparam int W = `ARRAYWIDTH;
    localparam int D = `DATASIZE;

    logic           clk;
    logic           rst;
    logic           start;
    logic [7:0]     base_addr;
    logic           rd_en;
    logic [7:0]     rd_addr;
    logic [W*D-1:0] rd_data;
    logic           load_en;
    logic [W*D-1:0] load_data;
    logic           out_en;
    logic           sr_rst;
    logic           busy;
    logic           done;

    int checks   = 0;
    int failures = 0;

    input_feed_ctrl #(.ADDRWIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .load_en   (load_en),
        .load_data (load_data),
        .out_en    (out_en),
        .sr_rst    (sr_rst),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Buffer contents: each address holds a distinct column pattern.
    function automatic logic [W*D-1:0] col_val(input logic [7:0] a);
        logic [W*D-1:0] v;
        v = '0;
        for (int r = 0; r < W; r++) v[r*D +: D] = D'(int'(a) * 3 + r * 41 + 5);
        return v;
    endfunction

    // Tile buffer with one-cycle read latency.
    always @(posedge clk) rd_data <= rd_en ? col_val(rd_addr) : '0;

    // Entered in cycle 0 (just after an edge); start is driven for cycle 0.
    // Cycles 1..22 are checked per cycle, cycle 23 must be idle again.
    task automatic run_tile(input logic [7:0] base, input bit noise, input string name);
        logic [5:0]     ctl_a, ctl_e, ctl_fa, ctl_fe;
        logic [7:0]     ad_e, ad_fa, ad_fe;
        logic [W*D-1:0] ld_e, ld_fa, ld_fe;
        int bad_ctl = -1;
        int bad_ad  = -1;
        int bad_ld  = -1;
        int bad_ov  = -1;
        int dones   = 0;
        start     = 1'b1;
        base_addr = base;
        for (int c = 1; c <= 22; c++) begin
            @(posedge clk);
            #1;
            start = noise && (c == 3 || c == 10 || c == 22);
            base_addr = 8'hA5;
            ctl_a = {rd_en, load_en, out_en, done, sr_rst, busy};
            ctl_e = {c <= 4, c >= 2 && c <= 5, c >= 6 && c <= 21, c == 22, c == 22, 1'b1};
            if (ctl_a !== ctl_e && bad_ctl < 0) begin
                bad_ctl = c; ctl_fa = ctl_a; ctl_fe = ctl_e;
            end
            ad_e = base + 8'(c - 1);
            if (c <= 4 && rd_addr !== ad_e && bad_ad < 0) begin
                bad_ad = c; ad_fa = rd_addr; ad_fe = ad_e;
            end
            ld_e = (c >= 2 && c <= 5) ? col_val(base + 8'(c - 2)) : '0;
            if (load_data !== ld_e && bad_ld < 0) begin
                bad_ld = c; ld_fa = load_data; ld_fe = ld_e;
            end
            if (load_en === 1'b1 && out_en === 1'b1 && bad_ov < 0) bad_ov = c;
            if (done === 1'b1) dones++;
        end
        checks++;
        if (bad_ctl >= 0) begin
            failures++;
            $display("FAIL %s ctl cycle %0d {rd_en,load_en,out_en,done,sr_rst,busy} got %b expected %b", name, bad_ctl, ctl_fa, ctl_fe);
        end
        checks++;
        if (bad_ad >= 0) begin
            failures++;
            $display("FAIL %s rd_addr cycle %0d got %h expected %h", name, bad_ad, ad_fa, ad_fe);
        end
        checks++;
        if (bad_ld >= 0) begin
            failures++;
            $display("FAIL %s load_data cycle %0d got %h expected %h", name, bad_ld, ld_fa, ld_fe);
        end
        checks++;
        if (bad_ov >= 0) begin
            failures++;
            $display("FAIL %s overlap load_en and out_en both high at cycle %0d expected never", name, bad_ov);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL %s done_count got %0d expected 1", name, dones);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, rd_en, done} !== 3'b000) begin
            failures++;
            $display("FAIL %s idle_after {busy,rd_en,done} got %b expected 000", name, {busy, rd_en, done});
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rd_en, load_en, out_en, sr_rst, busy, done} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctl got %b expected 000000", {rd_en, load_en, out_en, sr_rst, busy, done});
        end
        checks++;
        if (rd_addr !== 8'h00 || load_data !== '0) begin
            failures++;
            $display("FAIL reset_data rd_addr %h load_data %h expected 00 and 0", rd_addr, load_data);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        run_tile(8'h10, 1'b0, "basic");
    endtask

    task automatic test_wrap();
        run_tile(8'hFE, 1'b0, "wrap");
    endtask

    task automatic test_ignore_start();
        run_tile(8'h30, 1'b1, "ignore_start");
    endtask

    task automatic test_back_to_back();
        run_tile(8'h20, 1'b0, "back_to_back");
    endtask

    task automatic test_abort();
        int seen_done = 0;
        int seen_busy = 0;
        start     = 1'b1;
        base_addr = 8'h40;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        checks++;
        if (out_en !== 1'b1) begin
            failures++;
            $display("FAIL abort_in_stream out_en at cycle 10 got %b expected 1", out_en);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({rd_en, load_en, out_en, sr_rst, busy, done} !== 6'b0 || load_data !== '0) begin
            failures++;
            $display("FAIL abort_clear ctl got %b load_data %h expected 000000 and 0", {rd_en, load_en, out_en, sr_rst, busy, done}, load_data);
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen_done++;
            if (busy === 1'b1) seen_busy++;
        end
        checks++;
        if (seen_done != 0 || seen_busy != 0) begin
            failures++;
            $display("FAIL abort_quiet done cycles %0d busy cycles %0d expected 0 and 0", seen_done, seen_busy);
        end
        run_tile(8'h50, 1'b0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
